pulse_meter: RTL

//   Downstream consumer of the pulse generator's output train. Synchronises the incoming pulse and

---
 rtl/pulse_meter_pkg.sv | 30 +++
 rtl/pulse_meter_if.sv | 24 ++
 rtl/pulse_meter_sync_edge.sv | 41 ++++
 rtl/pulse_meter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pulse_pkg (package)
// Purpose : Shared types for the pulse meter: FSM state encoding, the
//           measurement record, and the rising-edge counter width.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
package pulse_pkg;

  // Width of the free-running rising-edge counter.
  localparam int PCNT_W = 16;

  // Widest counter a record can carry. CNT_W on the meter must not exceed this.
  localparam int REC_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  typedef struct packed {
    logic [REC_CNT_W-1:0] high;
    logic [REC_CNT_W-1:0] period;
    logic                 err;
  } rec_t;

endpackage
`default_nettype wire

// File: rtl/pulse_meter_if.sv
`default_nettype none
// ============================================================================
// Module  : pulse_meter_if (interface)
// Purpose : valid/ready measurement record channel.
// Signals : valid  - a record is held          (master -> slave)
//           ready  - consumer accepts record   (slave  -> master)
//           high   - high width in cycles      (master -> slave)
//           period - rise-to-rise period       (master -> slave)
//           err    - period out of range / counter saturated
// Revision: 1.0 - initial release
// ============================================================================
interface pulse_meter_if #(
  parameter int CNT_W = 8
);
  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] high;
  logic [CNT_W-1:0] period;
  logic             err;

  modport master (output valid, output high, output period, output err, input ready);
  modport slave  (input valid, input high, input period, input err, output ready);
endinterface
`default_nettype wire

// File: rtl/pulse_meter_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : pulse_sync_edge
// Purpose : Multi-flop synchroniser for an asynchronous pulse plus a one-cycle
//           delayed copy, giving single-cycle rise/fall strobes.
// Ports   : clk, reset (async, active-high), pulse (async input)
//           s    - synchronised pulse
//           rise - s & ~s_d
//           fall - ~s & s_d
// Revision: 1.0 - initial release
// ============================================================================
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  pulse,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule
`default_nettype wire

// File: rtl/pulse_meter.sv
`default_nettype none
// ============================================================================
// Module  : pulse_meter
// Purpose : Measures high width and rise-to-rise period of a pulse train and
//           reports one record per completed period over valid/ready.
// Ports   : clk, reset (async, active-high)
//           pulse     - asynchronous pulse train
//           en        - measurement enable
//           m         - record channel (master)
//           pulse_cnt - rising edges seen while en=1, wraps
//           lost      - sticky, a record was dropped because output was full
// Revision: 1.0 - initial release
// ============================================================================
module pulse_meter
  import pulse_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 2,
  parameter int MAX_PERIOD  = 200
) (
  input  wire               clk,
  input  wire               reset,
  input  wire               pulse,
  input  wire               en,
  pulse_meter_if.master     m,
  output logic [PCNT_W-1:0] pulse_cnt,
  output logic              lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_P   = CNT_W'(MAX_PERIOD);

  logic s, rise, fall;

  pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .pulse (pulse),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  state_t           state, state_nxt;
  logic             emit;
  logic [CNT_W-1:0] p_cnt, h_cnt;
  logic             sat;
  rec_t             rec_new, held;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (rise) state_nxt = ST_HIGH;
        // A rise while still HIGH means the fall was not seen; close the
        // period exactly as from LOW.
        ST_HIGH: begin
          if (rise) begin
            emit      = 1'b1;
            state_nxt = ST_HIGH;
          end else if (fall) begin
            state_nxt = ST_LOW;
          end
        end
        ST_LOW: begin
          if (rise) begin
            emit      = 1'b1;
            state_nxt = ST_HIGH;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------- counters ----------------
  // sat is raised as soon as either counter reaches its maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_cnt <= '0;
      h_cnt <= '0;
      sat   <= 1'b0;
    end else if (en && rise) begin
      p_cnt <= CNT_ONE;
      h_cnt <= CNT_ONE;
      sat   <= 1'b0;
    end else if (state != ST_IDLE) begin
      if (p_cnt != CNT_MAX) p_cnt <= p_cnt + CNT_ONE;
      if (p_cnt >= CNT_MAX - CNT_ONE) sat <= 1'b1;
      if (state == ST_HIGH && s) begin
        if (h_cnt != CNT_MAX) h_cnt <= h_cnt + CNT_ONE;
        if (h_cnt >= CNT_MAX - CNT_ONE) sat <= 1'b1;
      end
    end
  end

  // Record uses the counter values before the reload in the rise cycle.
  always_comb begin
    rec_new        = '0;
    rec_new.high   = REC_CNT_W'(h_cnt);
    rec_new.period = REC_CNT_W'(p_cnt);
    rec_new.err    = sat | (p_cnt < MIN_P) | (p_cnt > MAX_P);
  end

  // ---------------- single-entry output register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held    <= '0;
      m.valid <= 1'b0;
      lost    <= 1'b0;
    end else if (emit) begin
      if (!m.valid || m.ready) begin
        held    <= rec_new;
        m.valid <= 1'b1;
      end else begin
        lost    <= 1'b1;
      end
    end else if (m.valid && m.ready) begin
      m.valid <= 1'b0;
    end
  end

  assign m.high   = held.high[CNT_W-1:0];
  assign m.period = held.period[CNT_W-1:0];
  assign m.err    = held.err;

  // Upper record bits are always zero when CNT_W is narrower than a record.
  generate
    if (CNT_W < REC_CNT_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^{held.high[REC_CNT_W-1:CNT_W], held.period[REC_CNT_W-1:CNT_W]};
    end
  endgenerate

  // ---------------- rising-edge counter ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           pulse_cnt <= '0;
    else if (en && rise) pulse_cnt <= pulse_cnt + 1'b1;
  end

endmodule
`default_nettype wire
